control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
Multi-cycle successor to the single-cycle combinational control decoder. Sequences IDLE/FETCH/EXEC/MEM_WAIT/HALT itself instead of taking an external state bit, and stalls on a memory-ready handshake. Replaces the single saved-PC call/return with an internal return-address stack of parametrised depth. Sits between the instruction register (opcode, eoe fields), the datapath (Z flag, mux selects) and data memory.

Parameters:
OPW, 4, opcode width; MSB selects ALU (0) vs. control/memory class (1); FS is the full opcode
EOEW, 4, width of the eoe sub-field used by opcode 1_111
PCW, 8, program-counter width stored on the return stack
RAS_DEPTH, 4, return-stack entries (>=1)
MEM_TIMEOUT, 15, max MEM_WAIT cycles (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching
opcode  in  OPW  current instruction opcode, stable from EXEC until instruction retires
eoe  in  EOEW  sub-field for opcode 1_111
Z  in  1  datapath zero flag
mem_ready  in  1  data memory completed current LD/ST
pc_in  in  PCW  PC value to push on CALL
PS  out  2  PC select: 00 hold, 01 increment, 10 branch/jump offset, 11 load ras_top
IL  out  1  instruction register load
MB  out  1  immediate select
FS  out  OPW  ALU function (= opcode)
MD  out  1  memory-to-register select
RW  out  1  register write
MW  out  1  memory write
MP  out  1  write PC into register file (CALL link)
ras_top  out  PCW  top-of-stack return address
ras_cnt  out  $clog2(RAS_DEPTH+1)  valid entries
busy  out  1  high in FETCH/EXEC/MEM_WAIT
halted  out  1  high in HALT
fault  out  1  sticky error flag; clears only on reset

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; ras_cnt 0; fault 0.
- IDLE: all controls 0. start=1 -> FETCH next edge.
- FETCH: IL=1, other controls 0, PS=00. Always -> EXEC. Lasts exactly 1 cycle.
- EXEC decode, all controls combinational from state+opcode; unlisted controls 0; FS=opcode in every state except IDLE/HALT (0):
  ALU (MSB 0): RW=1, PS=01.
  000 LDI: MB=1, RW=1, PS=01.
  001 LD: MD=1. mem_ready=1 -> RW=1, PS=01, ->FETCH; else PS=00, ->MEM_WAIT.
  010 ST: MW=1. Same ready rule; PS=01 only on completing cycle.
  011 BZ: PS = Z?10:01. 100 BNZ: PS = Z?01:10.
  101 CALL: stack not full -> push pc_in, MP=1, RW=1, PS=10. Full -> fault=1, all controls 0, ->HALT.
  110 JMP: PS=10.
  111: eoe=0 (RET): stack non-empty -> PS=11, pop; empty -> fault, ->HALT. eoe=all-ones -> ->HALT, PS=00. Other eoe -> fault, ->HALT.
  All non-halting completions -> FETCH.
- MEM_WAIT: holds MD (LD) or MW (ST) with PS=00, RW=0; on mem_ready=1 asserts LD: RW=1/ST: MW=1 with PS=01, ->FETCH. Instruction latency = 2 + wait cycles.
- HALT: all controls 0, halted=1; absorbing until reset; start ignored.
- Stack: push writes entry[ras_cnt] and increments on edge; pop decrements; ras_top = entry[ras_cnt-1], 0 when empty. No wrap: overflow/underflow are faults, never silent.
- Reset mid-MEM_WAIT: immediate return to IDLE, no partial write asserted after rst_n low.

Optional Feature:
CTRL_MEM_TIMEOUT_EN: defined -> saturating counter in MEM_WAIT; after MEM_TIMEOUT cycles without mem_ready, fault=1, controls 0, ->HALT. Counter clears on entering MEM_WAIT. Not defined -> MEM_WAIT waits indefinitely; no counter logic.

Decomposition:
Shared package: state encoding (IDLE, FETCH, EXEC, MEM_WAIT, HALT), opcode subcode constants (LDI..SYS), PS encodings (PS_HOLD, PS_INC, PS_OFF, PS_RAS), EOE_RET/EOE_END values. One sub-module: return_stack (push/pop/top/count/full/empty, parametrised PCW, RAS_DEPTH).

Test Plan:
- Reset, start=1, opcode=0_011 -> FETCH: IL=1; EXEC: RW=1, PS=01, FS=0011; back to FETCH.
- LD with mem_ready low 3 cycles -> MEM_WAIT 3 cycles with MD=1, PS=00, RW=0; ready cycle RW=1, PS=01.
- BZ with Z=1 -> PS=10; Z=0 -> PS=01; BNZ mirror.
- RAS_DEPTH=4: 4 CALLs with pc_in=0x10..0x13 -> ras_cnt=4, ras_top=0x13; 5th CALL -> fault=1, halted=1; alternative path: 4 RETs yield PS=11 with ras_top 0x13,0x12,0x11,0x10.
- RET on empty stack -> fault, HALT; opcode 1_111 eoe=1111 -> halted=1, fault=0, start ignored.
- With CTRL_MEM_TIMEOUT_EN, MEM_TIMEOUT=15: ST with mem_ready stuck 0 -> fault at 15th wait cycle; rst_n low mid-wait -> all outputs 0 immediately.

Source files
------------

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle control sequencer: state codes, opcode
// subcodes, PC-select values and the eoe patterns used by opcode 1_111.
package control_fsm_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_EXEC     = 3'd2;
    localparam logic [2:0] ST_MEM_WAIT = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;

    // Low three opcode bits when the class bit (MSB) is set
    localparam logic [2:0] OP_LDI  = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ST   = 3'd2;
    localparam logic [2:0] OP_BZ   = 3'd3;
    localparam logic [2:0] OP_BNZ  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_SYS  = 3'd7;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_OFF  = 2'b10;
    localparam logic [1:0] PS_RAS  = 2'b11;

    // eoe patterns are a replicated bit so they scale with EOEW
    localparam logic EOE_RET = 1'b0;
    localparam logic EOE_END = 1'b1;

    typedef struct packed {
        logic [1:0] ps;
        logic       il;
        logic       mb;
        logic       md;
        logic       rw;
        logic       mw;
        logic       mp;
    } ctrl_t;

endpackage

// File: rtl/control_fsm_return_stack.sv
// Return-address stack: push writes entry[cnt], pop drops the top entry.
// Overflow/underflow are refused here and reported as faults by the sequencer.
module return_stack
    import control_fsm_pkg::*;
#(
    parameter int PCW       = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [PCW-1:0]                 din,
    output logic [PCW-1:0]                 top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] cnt,
    output logic                           full,
    output logic                           empty
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [PCW-1:0] entry [RAS_DEPTH];

    assign full  = (cnt == CW'(RAS_DEPTH));
    assign empty = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) entry[i] <= '0;
        end else begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                if (push && !full && cnt == CW'(i)) entry[i] <= din;
            end
            if (push && !full) cnt <= cnt + CW'(1);
            else if (pop && !empty) cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (cnt == CW'(i + 1)) top = entry[i];
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer with memory-ready stall and return-address stack.
// Optional MEM_WAIT watchdog: define CTRL_MEM_TIMEOUT_EN.
//
// state       | meaning
// IDLE        | waiting for start, all controls low
// FETCH       | load instruction register (1 cycle)
// EXEC        | decode opcode and drive datapath controls
// MEM_WAIT    | LD/ST stalled until mem_ready
// HALT        | absorbing stop, left only by reset
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int EOEW        = 4,
    parameter int PCW         = 8,
    parameter int RAS_DEPTH   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [OPW-1:0]                 opcode,
    input  logic [EOEW-1:0]                eoe,
    input  logic                           Z,
    input  logic                           mem_ready,
    input  logic [PCW-1:0]                 pc_in,
    output logic [1:0]                     PS,
    output logic                           IL,
    output logic                           MB,
    output logic [OPW-1:0]                 FS,
    output logic                           MD,
    output logic                           RW,
    output logic                           MW,
    output logic                           MP,
    output logic [PCW-1:0]                 ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt,
    output logic                           busy,
    output logic                           halted,
    output logic                           fault
);
    if (RAS_DEPTH < 1 || MEM_TIMEOUT < 1) begin : g_bad_param
        $error("control_fsm: RAS_DEPTH and MEM_TIMEOUT must be >= 1");
    end

    logic [2:0] state, nxt;
    ctrl_t      c;
    logic       push, pop, err, ras_full, ras_empty, to_hit;
    logic [2:0] sub;

    assign sub = opcode[2:0];

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt <= '0;
        else if (state != ST_MEM_WAIT) to_cnt <= '0;
        else if (to_cnt != TW'(MEM_TIMEOUT)) to_cnt <= to_cnt + TW'(1);
    end

    assign to_hit = (state == ST_MEM_WAIT) && !mem_ready && (to_cnt >= TW'(MEM_TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        c    = '0;
        nxt  = state;
        push = 1'b0;
        pop  = 1'b0;
        err  = 1'b0;
        case (state)
            ST_IDLE:  if (start) nxt = ST_FETCH;
            ST_FETCH: begin
                c.il = 1'b1;
                nxt  = ST_EXEC;
            end
            ST_EXEC: begin
                nxt = ST_FETCH;
                if (!opcode[OPW-1]) begin
                    c.rw = 1'b1;
                    c.ps = PS_INC;
                end else begin
                    case (sub)
                        OP_LDI: begin
                            c.mb = 1'b1;
                            c.rw = 1'b1;
                            c.ps = PS_INC;
                        end
                        OP_LD: begin
                            c.md = 1'b1;
                            if (mem_ready) begin
                                c.rw = 1'b1;
                                c.ps = PS_INC;
                            end else nxt = ST_MEM_WAIT;
                        end
                        OP_ST: begin
                            c.mw = 1'b1;
                            if (mem_ready) c.ps = PS_INC;
                            else nxt = ST_MEM_WAIT;
                        end
                        OP_BZ:  c.ps = Z ? PS_OFF : PS_INC;
                        OP_BNZ: c.ps = Z ? PS_INC : PS_OFF;
                        OP_CALL: begin
                            if (!ras_full) begin
                                push = 1'b1;
                                c.mp = 1'b1;
                                c.rw = 1'b1;
                                c.ps = PS_OFF;
                            end else begin
                                err = 1'b1;
                                nxt = ST_HALT;
                            end
                        end
                        OP_JMP: c.ps = PS_OFF;
                        default: begin
                            if (eoe == {EOEW{EOE_RET}} && !ras_empty) begin
                                c.ps = PS_RAS;
                                pop  = 1'b1;
                            end else begin
                                // clean END halts quietly; empty RET and unknown eoe are faults
                                err = (eoe != {EOEW{EOE_END}});
                                nxt = ST_HALT;
                            end
                        end
                    endcase
                end
            end
            ST_MEM_WAIT: begin
                if (to_hit) begin
                    err = 1'b1;
                    nxt = ST_HALT;
                end else begin
                    c.md = (sub != OP_ST);
                    c.mw = (sub == OP_ST);
                    if (mem_ready) begin
                        c.rw = (sub != OP_ST);
                        c.ps = PS_INC;
                        nxt  = ST_FETCH;
                    end
                end
            end
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            fault <= 1'b0;
        end else begin
            state <= nxt;
            if (err) fault <= 1'b1;
        end
    end

    return_stack #(.PCW(PCW), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_in),
        .top   (ras_top),
        .cnt   (ras_cnt),
        .full  (ras_full),
        .empty (ras_empty)
    );

    assign PS     = c.ps;
    assign IL     = c.il;
    assign MB     = c.mb;
    assign MD     = c.md;
    assign RW     = c.rw;
    assign MW     = c.mw;
    assign MP     = c.mp;
    assign FS     = (state == ST_IDLE || state == ST_HALT) ? '0 : opcode;
    assign busy   = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_MEM_WAIT);
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_control_fsm.sv
// Instruction-level bench for control_fsm: each instruction's cycle-by-cycle
// controls are predicted from the opcode rules, with a queue as the return stack.
module tb_control_fsm;
    localparam int RAS_DEPTH = 4;
    localparam logic [1:0] H = 2'd0, I = 2'd1, O = 2'd2, R = 2'd3;

    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [3:0] opcode = '0, eoe = '0;
    logic       Z = 1'b0, mem_ready = 1'b0;
    logic [7:0] pc_in = '0;
    logic [1:0] PS;
    logic       IL, MB, MD, RW, MW, MP, busy, halted, fault;
    logic [3:0] FS;
    logic [7:0] ras_top;
    logic [2:0] ras_cnt;

    control_fsm #(.OPW(4), .EOEW(4), .PCW(8), .RAS_DEPTH(RAS_DEPTH), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .eoe(eoe), .Z(Z),
        .mem_ready(mem_ready), .pc_in(pc_in), .PS(PS), .IL(IL), .MB(MB), .FS(FS), .MD(MD),
        .RW(RW), .MW(MW), .MP(MP), .ras_top(ras_top), .ras_cnt(ras_cnt), .busy(busy),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int         checks = 0, failures = 0;
    logic [7:0] stk[$];
    logic       m_fault = 1'b0;
    bit         h;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // flags = {IL,MB,MD,RW,MW,MP}; st = {busy,halted}
    function automatic logic [13:0] pk(input logic [1:0] ps, input logic [5:0] flags,
                                       input logic [3:0] fs, input logic [1:0] st);
        return {ps, flags, fs, st};
    endfunction

    task automatic chk_out(input string tag, input logic [13:0] exp);
        chk(tag, 32'({PS, IL, MB, MD, RW, MW, MP, FS, busy, halted}), 32'(exp));
    endtask

    task automatic chk_stack(input string tag);
        chk({tag, "_cnt"}, 32'(ras_cnt), 32'(stk.size()));
        chk({tag, "_top"}, 32'(ras_top), 32'(stk.size() > 0 ? stk[$] : 8'h00));
        chk({tag, "_fault"}, 32'(fault), 32'(m_fault));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        stk.delete();
        m_fault = 1'b0;
        chk_out("reset", pk(H, 6'b0, 4'h0, 2'b00));
        chk_stack("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        @(negedge clk);
        chk_out("idle", pk(H, 6'b0, 4'h0, 2'b00));
        tick();
        start = 1'b0;
    endtask

    task automatic chk_hold();
        start = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_out("hold", pk(H, 6'b0, 4'h0, 2'b01));
        chk_stack("hold");
        start = 1'b0;
        tick();
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] e, input logic z,
                             input int nw, input logic [7:0] pc, output bit hlt);
        logic [13:0] x;
        bit push_m, pop_m, err_m, mem_op, is_ld;
        hlt = 0; push_m = 0; pop_m = 0; err_m = 0;
        opcode = op; eoe = e; Z = z; pc_in = pc; mem_ready = 1'b0;
        @(negedge clk);
        chk_stack("fetch");
        chk_out("fetch", pk(H, 6'b100000, op, 2'b10));
        tick();
        is_ld  = (op == 4'b1001);
        mem_op = is_ld || (op == 4'b1010);
        mem_ready = mem_op ? (nw == 0) : 1'($urandom_range(0, 1));
        x = pk(H, 6'b0, op, 2'b10);
        if (!op[3]) x = pk(I, 6'b000100, op, 2'b10);
        else begin
            case (op[2:0])
                3'd0: x = pk(I, 6'b010100, op, 2'b10);
                3'd1: x = (nw == 0) ? pk(I, 6'b001100, op, 2'b10) : pk(H, 6'b001000, op, 2'b10);
                3'd2: x = (nw == 0) ? pk(I, 6'b000010, op, 2'b10) : pk(H, 6'b000010, op, 2'b10);
                3'd3: x = pk(z ? O : I, 6'b0, op, 2'b10);
                3'd4: x = pk(z ? I : O, 6'b0, op, 2'b10);
                3'd5: begin
                    if (stk.size() < RAS_DEPTH) begin
                        x = pk(O, 6'b000101, op, 2'b10);
                        push_m = 1;
                    end else begin
                        err_m = 1; hlt = 1;
                    end
                end
                3'd6: x = pk(O, 6'b0, op, 2'b10);
                default: begin
                    if (e == 4'h0 && stk.size() > 0) begin
                        x = pk(R, 6'b0, op, 2'b10);
                        pop_m = 1;
                    end else begin
                        err_m = (e != 4'hF);
                        hlt = 1;
                    end
                end
            endcase
        end
        @(negedge clk);
        chk_out("exec", x);
        if (mem_op) begin
            for (int k = 1; k <= nw; k++) begin
                tick();
                mem_ready = (k == nw);
                @(negedge clk);
                if (k < nw) x = is_ld ? pk(H, 6'b001000, op, 2'b10) : pk(H, 6'b000010, op, 2'b10);
                else        x = is_ld ? pk(I, 6'b001100, op, 2'b10) : pk(I, 6'b000010, op, 2'b10);
                chk_out("wait", x);
            end
        end
        tick();
        if (push_m) stk.push_back(pc);
        if (pop_m) void'(stk.pop_back());
        if (err_m) m_fault = 1'b1;
        if (hlt) begin
            @(negedge clk);
            chk_out("halt", pk(H, 6'b0, 4'h0, 2'b01));
            chk_stack("halt");
        end
    endtask

    initial begin
        logic [3:0] op, e;
        int r;
        #2;
        do_reset();
        begin_run();
        run_instr(4'b0011, 4'h0, 1'b0, 0, 8'h00, h);
        run_instr(4'b1001, 4'h0, 1'b0, 3, 8'h00, h);
        run_instr(4'b1010, 4'h0, 1'b0, 2, 8'h00, h);
        run_instr(4'b1000, 4'h0, 1'b0, 0, 8'h00, h);
        run_instr(4'b1011, 4'h0, 1'b1, 0, 8'h00, h);
        run_instr(4'b1011, 4'h0, 1'b0, 0, 8'h00, h);
        run_instr(4'b1100, 4'h0, 1'b1, 0, 8'h00, h);
        run_instr(4'b1100, 4'h0, 1'b0, 0, 8'h00, h);
        run_instr(4'b1110, 4'h0, 1'b0, 0, 8'h00, h);
        for (int i = 0; i < 4; i++) run_instr(4'b1101, 4'h0, 1'b0, 0, 8'(8'h10 + i), h);
        for (int i = 0; i < 4; i++) run_instr(4'b1111, 4'h0, 1'b0, 0, 8'h00, h);
        run_instr(4'b1111, 4'h0, 1'b0, 0, 8'h00, h);
        chk_hold();

        do_reset();
        begin_run();
        for (int i = 0; i < 5; i++) run_instr(4'b1101, 4'h0, 1'b0, 0, 8'(8'h10 + i), h);
        chk_hold();

        do_reset();
        begin_run();
        run_instr(4'b1111, 4'hF, 1'b0, 0, 8'h00, h);
        chk_hold();

        do_reset();
        begin_run();
        run_instr(4'b1111, 4'h5, 1'b0, 0, 8'h00, h);
        chk_hold();

        do_reset();
        begin_run();
        opcode = 4'b1010; mem_ready = 1'b0;
        @(negedge clk);
        chk_out("mw_fetch", pk(H, 6'b100000, 4'b1010, 2'b10));
        tick();
        @(negedge clk);
        chk_out("mw_exec", pk(H, 6'b000010, 4'b1010, 2'b10));
        tick();
        @(negedge clk);
        chk_out("mw_wait", pk(H, 6'b000010, 4'b1010, 2'b10));
        #2;
        do_reset();

`ifdef CTRL_MEM_TIMEOUT_EN
        begin_run();
        opcode = 4'b1010; mem_ready = 1'b0;
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
            @(negedge clk);
            if (k < 15) chk_out("to_wait", pk(H, 6'b000010, 4'b1010, 2'b10));
            else        chk_out("to_last", pk(H, 6'b0, 4'b1010, 2'b10));
        end
        tick();
        m_fault = 1'b1;
        @(negedge clk);
        chk_out("to_halt", pk(H, 6'b0, 4'h0, 2'b01));
        chk_stack("to_halt");
        do_reset();
`endif

        begin_run();
        h = 0;
        for (int n = 0; n < 400; n++) begin
            if (h) begin
                do_reset();
                begin_run();
            end
            op = 4'($urandom_range(0, 15));
            r  = int'($urandom_range(0, 9));
            e  = (r < 7) ? 4'h0 : (r == 7) ? 4'hF : 4'($urandom_range(1, 14));
            run_instr(op, e, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      8'($urandom), h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
